// File: rtl/l2_rolling_ratio_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | l2_rolling_ratio_sampler                                                   |
// | Windows late/issued prefetch counts and emits one registered sample per    |
// | window. Optional macro L2_ROLLING_WARMUP_EN drops the first windows.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module l2_rolling_ratio_sampler #(
  parameter int unsigned WINDOW         = 1000,
  parameter int unsigned INC_W          = 4,
  parameter int unsigned WARMUP_WINDOWS = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             perf_enable,
  input  logic [INC_W-1:0] num_inc,
  input  logic [INC_W-1:0] den_inc,
  input  logic             flush,
  output logic             out_en,
  output logic [63:0]      out_yAxisPt,
  output logic [63:0]      out_xAxisPt,
  output logic [63:0]      out_stamp,
  output logic             done
);

  localparam logic [63:0] c_window = 64'(WINDOW);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [63:0] r_num_acc;
  logic [63:0] r_den_acc;
  logic [63:0] r_x_total;
  logic [63:0] r_cyc;
  logic        r_out_en;
  logic [63:0] r_y;
  logic [63:0] r_x;
  logic [63:0] r_stamp;

  logic        w_run;
  logic [63:0] w_num_add;
  logic [63:0] w_den_add;
  logic [63:0] w_nsum;
  logic [63:0] w_dsum;
  logic [63:0] w_xsum;
  logic [63:0] w_num_acc_next;
  logic [63:0] w_den_acc_next;
  logic        w_complete;
  logic        w_partial;
  logic        w_emit;
  logic        w_warm_ok;

`ifdef L2_ROLLING_WARMUP_EN
  localparam int unsigned c_warm_w = (WARMUP_WINDOWS < 1) ? 1 : $clog2(WARMUP_WINDOWS + 1);
  localparam logic [c_warm_w-1:0] c_warm_target = c_warm_w'(WARMUP_WINDOWS);

  logic [c_warm_w-1:0] r_warm_cnt;

  assign w_warm_ok = (r_warm_cnt >= c_warm_target);

  // Saturates at the target so emission stays enabled forever after warm-up
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_warm_cnt <= '0;
    end else if (w_complete && !w_warm_ok) begin
      r_warm_cnt <= r_warm_cnt + c_warm_w'(1);
    end
  end
`else
  assign w_warm_ok = 1'b1 | WARMUP_WINDOWS[0];
`endif

  always_comb begin
    w_run          = (r_state == ST_RUN);
    w_num_add      = (w_run && perf_enable) ? 64'(num_inc) : 64'd0;
    w_den_add      = (w_run && perf_enable) ? 64'(den_inc) : 64'd0;
    w_nsum         = r_num_acc + w_num_add;
    w_dsum         = r_den_acc + w_den_add;
    w_xsum         = r_x_total + w_den_add;
    w_complete     = w_run && (w_dsum >= c_window);
    w_partial      = w_run && flush && ((w_nsum != 64'd0) || (w_dsum != 64'd0));
    w_emit         = (w_complete || w_partial) && w_warm_ok;
    w_state_next   = r_state;
    w_num_acc_next = w_nsum;
    w_den_acc_next = w_dsum;
    // Overshoot beyond WINDOW is discarded here but survives in x_total
    if (w_complete) begin
      w_num_acc_next = 64'd0;
      w_den_acc_next = 64'd0;
    end
    if (w_run && flush) begin
      w_state_next = ST_DONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_num_acc <= 64'd0;
      r_den_acc <= 64'd0;
      r_x_total <= 64'd0;
      r_cyc     <= 64'd0;
      r_out_en  <= 1'b0;
      r_y       <= 64'd0;
      r_x       <= 64'd0;
      r_stamp   <= 64'd0;
    end else begin
      r_cyc     <= r_cyc + 64'd1;
      r_num_acc <= w_num_acc_next;
      r_den_acc <= w_den_acc_next;
      r_x_total <= w_xsum;
      r_out_en  <= w_emit;
      if (w_emit) begin
        r_y     <= w_nsum;
        r_x     <= w_xsum;
        r_stamp <= r_cyc;
      end
    end
  end

  assign out_en      = r_out_en;
  assign out_yAxisPt = r_y;
  assign out_xAxisPt = r_x;
  assign out_stamp   = r_stamp;
  assign done        = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_l2_rolling_ratio_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_l2_rolling_ratio_sampler                                                |
// | Directed self-checking bench, WINDOW=4, INC_W=4, WARMUP_WINDOWS=2.        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_l2_rolling_ratio_sampler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        perf_enable = 1'b1;
  logic [3:0]  num_inc = 4'd0;
  logic [3:0]  den_inc = 4'd0;
  logic        flush = 1'b0;
  logic        out_en;
  logic [63:0] out_yAxisPt;
  logic [63:0] out_xAxisPt;
  logic [63:0] out_stamp;
  logic        done;

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  longint unsigned now = 0;

  l2_rolling_ratio_sampler #(
    .WINDOW        (4),
    .INC_W         (4),
    .WARMUP_WINDOWS(2)
  ) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .perf_enable(perf_enable),
    .num_inc    (num_inc),
    .den_inc    (den_inc),
    .flush      (flush),
    .out_en     (out_en),
    .out_yAxisPt(out_yAxisPt),
    .out_xAxisPt(out_xAxisPt),
    .out_stamp  (out_stamp),
    .done       (done)
  );

  always #5 clock = ~clock;

  // One clock with the given inputs; outputs are sampled 1ns after the edge
  task automatic drive(input logic pe, input logic [3:0] n, input logic [3:0] d, input logic f);
    perf_enable = pe;
    num_inc     = n;
    den_inc     = d;
    flush       = f;
    @(posedge clock);
    #1;
    now++;
    if (out_en === 1'b1) pulses++;
    perf_enable = 1'b1;
    num_inc     = 4'd0;
    den_inc     = 4'd0;
    flush       = 1'b0;
  endtask

  task automatic do_reset;
    reset_n     = 1'b0;
    perf_enable = 1'b1;
    num_inc     = 4'd0;
    den_inc     = 4'd0;
    flush       = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    now     = 0;
    pulses  = 0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({out_en, done} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flags: en=%0b done=%0b want 0 0", out_en, done);
    end
    total++;
    if ({out_yAxisPt, out_xAxisPt, out_stamp} !== 192'd0) begin
      bad++;
      $display("FAIL reset_data: y=%0d x=%0d st=%0d want 0 0 0", out_yAxisPt, out_xAxisPt, out_stamp);
    end
  endtask

  task automatic test_basic_window;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd1, 4'd1, 1'b0);
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL basic_early: pulses=%0d want 0", pulses);
    end
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd4, 64'd4, 64'd3}) begin
      bad++;
      $display("FAIL basic_emit: en=%0b y=%0d x=%0d st=%0d want 1 4 4 3", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt} !== {1'b0, 64'd4, 64'd4}) begin
      bad++;
      $display("FAIL basic_hold: en=%0b y=%0d x=%0d want 0 4 4", out_en, out_yAxisPt, out_xAxisPt);
    end
  endtask

  task automatic test_overshoot;
    do_reset();
    drive(1'b1, 4'd0, 4'd3, 1'b0);
    total++;
    if (out_en !== 1'b0) begin
      bad++;
      $display("FAIL over_partial: en=%0b want 0", out_en);
    end
    drive(1'b1, 4'd2, 4'd3, 1'b0);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd2, 64'd6, 64'd1}) begin
      bad++;
      $display("FAIL over_emit: en=%0b y=%0d x=%0d st=%0d want 1 2 6 1", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
    drive(1'b1, 4'd1, 4'd3, 1'b0);
    total++;
    if (out_en !== 1'b0) begin
      bad++;
      $display("FAIL over_restart: en=%0b want 0", out_en);
    end
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd2, 64'd10, 64'd3}) begin
      bad++;
      $display("FAIL over_second: en=%0b y=%0d x=%0d st=%0d want 1 2 10 3", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
  endtask

  task automatic test_flush_partial;
    do_reset();
    drive(1'b1, 4'd1, 4'd2, 1'b0);
    drive(1'b1, 4'd0, 4'd0, 1'b1);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp, done} !== {1'b1, 64'd1, 64'd2, 64'd1, 1'b1}) begin
      bad++;
      $display("FAIL flush_emit: en=%0b y=%0d x=%0d st=%0d done=%0b want 1 1 2 1 1",
               out_en, out_yAxisPt, out_xAxisPt, out_stamp, done);
    end
    pulses = 0;
    for (int i = 0; i < 4; i++) drive(1'b1, 4'd3, 4'd4, 1'b1);
    total++;
    if ({pulses == 0, done} !== 2'b11) begin
      bad++;
      $display("FAIL flush_sticky: pulses=%0d done=%0b want 0 1", pulses, done);
    end
    total++;
    if ({out_yAxisPt, out_xAxisPt} !== {64'd1, 64'd2}) begin
      bad++;
      $display("FAIL flush_hold: y=%0d x=%0d want 1 2", out_yAxisPt, out_xAxisPt);
    end
  endtask

  task automatic test_flush_on_completion;
    do_reset();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd1, 4'd1, 1'b0);
    drive(1'b1, 4'd1, 4'd1, 1'b1);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp, done} !== {1'b1, 64'd4, 64'd4, 64'd3, 1'b1}) begin
      bad++;
      $display("FAIL flushcomp_emit: en=%0b y=%0d x=%0d st=%0d done=%0b want 1 4 4 3 1",
               out_en, out_yAxisPt, out_xAxisPt, out_stamp, done);
    end
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL flushcomp_once: pulses=%0d want 1", pulses);
    end
  endtask

  task automatic test_flush_empty;
    do_reset();
    drive(1'b1, 4'd0, 4'd0, 1'b1);
    total++;
    if ({out_en, done} !== 2'b01) begin
      bad++;
      $display("FAIL empty_flush: en=%0b done=%0b want 0 1", out_en, done);
    end
    drive(1'b1, 4'd0, 4'd0, 1'b0);
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL empty_pulses: pulses=%0d want 0", pulses);
    end
  endtask

  task automatic test_perf_disable;
    do_reset();
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 4'd2, 4'd5, 1'b0);
    total++;
    if ({pulses == 0, out_xAxisPt} !== {1'b1, 64'd0}) begin
      bad++;
      $display("FAIL perf_off: pulses=%0d x=%0d want 0 0", pulses, out_xAxisPt);
    end
    drive(1'b0, 4'd0, 4'd0, 1'b1);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd1, 64'd1, 64'd11}) begin
      bad++;
      $display("FAIL perf_flush: en=%0b y=%0d x=%0d st=%0d want 1 1 1 11", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
  endtask

  task automatic test_async_reset;
    do_reset();
    drive(1'b1, 4'd0, 4'd2, 1'b0);
    drive(1'b1, 4'd3, 4'd2, 1'b0);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt} !== {1'b1, 64'd3, 64'd4}) begin
      bad++;
      $display("FAIL async_pre: en=%0b y=%0d x=%0d want 1 3 4", out_en, out_yAxisPt, out_xAxisPt);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp, done} !== 194'd0) begin
      bad++;
      $display("FAIL async_clear: en=%0b y=%0d x=%0d st=%0d done=%0b want all 0",
               out_en, out_yAxisPt, out_xAxisPt, out_stamp, done);
    end
    do_reset();
    drive(1'b1, 4'd0, 4'd3, 1'b0);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    now = 0;
    drive(1'b1, 4'd0, 4'd1, 1'b0);
    total++;
    if (out_en !== 1'b0) begin
      bad++;
      $display("FAIL async_lost: en=%0b want 0", out_en);
    end
    drive(1'b1, 4'd0, 4'd0, 1'b1);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd0, 64'd1, 64'd1}) begin
      bad++;
      $display("FAIL async_after: en=%0b y=%0d x=%0d st=%0d want 1 0 1 1", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
  endtask

  task automatic test_warmup;
    do_reset();
    for (int i = 0; i < 11; i++) drive(1'b1, 4'd1, 4'd1, 1'b0);
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL warm_discard: pulses=%0d want 0", pulses);
    end
    drive(1'b1, 4'd1, 4'd1, 1'b0);
    total++;
    if ({out_en, out_yAxisPt, out_xAxisPt, out_stamp} !== {1'b1, 64'd4, 64'd12, 64'd11}) begin
      bad++;
      $display("FAIL warm_first: en=%0b y=%0d x=%0d st=%0d want 1 4 12 11", out_en, out_yAxisPt, out_xAxisPt, out_stamp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time=%0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
`ifdef L2_ROLLING_WARMUP_EN
    test_warmup();
`else
    test_basic_window();
    test_overshoot();
    test_flush_partial();
    test_flush_on_completion();
    test_flush_empty();
    test_perf_disable();
    test_async_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_rolling_ratio_sampler.md
Name: l2_rolling_ratio_sampler

Overview:
- Upstream producer for the L2 rolling perf-record writer (prefetch-late rolling curve).
- Accumulates a per-cycle numerator increment (late prefetches) and denominator increment (prefetches issued) into windows sized by the denominator.
- Emits one registered sample per completed window: windowed numerator (y), cumulative denominator (x), cycle stamp.
- Outputs drive the writer's en/data_yAxisPt/data_xAxisPt/stamp directly; no back-pressure.

Parameters:
- WINDOW, 1000, denominator events per window; legal range 1..2^32-1.
- INC_W, 4, width of each per-cycle increment input.
- WARMUP_WINDOWS, 2, completed windows discarded after reset; used only under the optional feature.

Ports:
- clock  in  1  single clock for all state.
- reset_n  in  1  asynchronous, active-low reset.
- perf_enable  in  1  accumulate increments only when high.
- num_inc  in  INC_W  numerator events this cycle.
- den_inc  in  INC_W  denominator events this cycle.
- flush  in  1  one-cycle request to emit the partial window and stop.
- out_en  out  1  one-cycle sample-valid pulse.
- out_yAxisPt  out  64  numerator accumulated in the emitted window.
- out_xAxisPt  out  64  cumulative denominator since reset, including this window.
- out_stamp  out  64  cycle-counter value of the triggering cycle.
- done  out  1  high once a flush has been taken.

Behaviour:
- Reset (async assert, sync release): out_en=0, out_yAxisPt=0, out_xAxisPt=0, out_stamp=0, done=0. Accumulators num_acc, den_acc, x_total and cycle counter cyc all =0. State=RUN.
- cyc increments every cycle in every state, 64-bit, wraps modulo 2^64.
- RUN state, perf_enable=1:
  - nsum=num_acc+num_inc; dsum=den_acc+den_inc; xsum=x_total+den_inc.
  - If dsum >= WINDOW: emit (y=nsum, x=xsum, stamp=cyc), then num_acc=0, den_acc=0. Overshoot past WINDOW is dropped from the window but kept in x_total.
  - Otherwise num_acc=nsum, den_acc=dsum.
  - x_total=xsum always.
- RUN state, perf_enable=0: increments ignored; accumulators hold.
- Flush in RUN: emit the partial window (y=nsum, x=xsum, stamp=cyc) if nsum!=0 or dsum!=0; otherwise no emission. Then go to DONE, set done=1.
- Flush in the same cycle as a window completion: exactly one emission covering both.
- Emission latency: out_en and data are registered and appear the cycle after the triggering cycle. out_en is high for exactly one cycle.
- out_y/out_x/out_stamp hold their last emitted values between pulses.
- DONE: sticky until reset. No emissions; flush and increments ignored; cyc keeps running.
- Widths: num_acc, den_acc and x_total are 64-bit and wrap modulo 2^64 (not reachable in practice). Increments are zero-extended.
- reset_n asserted mid-window: all state clears immediately, including any pending out_en; the partial window is lost.

Optional Feature:
- Macro: L2_ROLLING_WARMUP_EN.
- With macro: a saturating counter discards the first WARMUP_WINDOWS window completions. Accumulators clear and x_total advances as normal, but out_en stays 0. A flush during warm-up also emits nothing, then enters DONE.
- Without macro: every completion emits; WARMUP_WINDOWS is unused.

Test Plan:
- WINDOW=4, macro off, perf_enable=1. den_inc=1 and num_inc=1 on cycles 0..3 -> out_en on cycle 4 with y=4, x=4, stamp=3.
- WINDOW=4: den_inc=3 on cycle 0, then den_inc=3, num_inc=2 on cycle 1 -> one pulse with y=2, x=6. Next window starts from den_acc=0; the next pulse reports cumulative x.
- Accumulate den=2, num=1, then flush -> pulse with y=1, x=2; done=1. Further increments and flushes produce no pulses.
- Flush on the cycle den reaches 4 -> exactly one pulse. Flush from reset with no events -> no pulse, done=1.
- perf_enable=0 with den_inc=5 for 10 cycles -> no pulses and x unchanged. Assert reset_n mid-window -> all outputs 0 asynchronously.
- L2_ROLLING_WARMUP_EN, WARMUP_WINDOWS=2, WINDOW=4, den_inc=1 every cycle -> first pulse at the third completion with x=12.
